// File: rtl/ft_wr_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------+
// | ft_wr_sched_if : IQ/CPU FIFO read ports + FT600 write-side bus  |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
interface ft_wr_sched_if #(
  parameter int FT_DATA_WIDTH = 32,
  parameter int IQ_PAIR_WIDTH = 24,
  parameter int LVL_WIDTH     = 10
);
  logic [IQ_PAIR_WIDTH-1:0] iq_data_i;
  logic                     iq_empty_i;
  logic [LVL_WIDTH-1:0]     iq_level_i;
  logic                     iq_re_o;
  logic [FT_DATA_WIDTH-1:0] cpu_data_i;
  logic                     cpu_empty_i;
  logic [LVL_WIDTH-1:0]     cpu_level_i;
  logic                     cpu_re_o;
  logic                     ft_rdy_o;
  logic [FT_DATA_WIDTH-1:0] ft_data_o;
  logic                     ft_last_o;
  logic                     ft_re_i;
  logic                     underrun_o;

  modport master (
    input  iq_data_i, iq_empty_i, iq_level_i,
    input  cpu_data_i, cpu_empty_i, cpu_level_i,
    input  ft_re_i,
    output iq_re_o, cpu_re_o, ft_rdy_o, ft_data_o, ft_last_o, underrun_o
  );

  modport slave (
    output iq_data_i, iq_empty_i, iq_level_i,
    output cpu_data_i, cpu_empty_i, cpu_level_i,
    output ft_re_i,
    input  iq_re_o, cpu_re_o, ft_rdy_o, ft_data_o, ft_last_o, underrun_o
  );
endinterface
`default_nettype wire

// File: rtl/ft_wr_sched.sv
`default_nettype none
// +----------------------------------------------------------------+
// | ft_wr_sched : header+payload FT600 write burst scheduler        |
// | arbitrating the AFE IQ stream FIFO and the ECPU response FIFO.  |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module ft_wr_sched #(
  parameter int FT_DATA_WIDTH   = 32,
  parameter int IQ_PAIR_WIDTH   = 24,
  parameter int LVL_WIDTH       = 10,
  parameter int IQ_BURST        = 256,
  parameter int CPU_BURST_MAX   = 16,
  parameter int IQ_FLUSH_CYCLES = 4096
) (
  input  wire logic  clk,
  input  wire logic  reset,
  ft_wr_sched_if.master bus
);

  localparam int              TMR_W      = (IQ_FLUSH_CYCLES > 1) ? $clog2(IQ_FLUSH_CYCLES) : 1;
  localparam int              IQ_HALF    = IQ_PAIR_WIDTH / 2;
  localparam logic [TMR_W-1:0] C_TMR_MAX = TMR_W'(IQ_FLUSH_CYCLES - 1);
  localparam logic [15:0]     C_IQ_BURST = 16'(IQ_BURST);
  localparam logic [15:0]     C_CPU_MAX  = 16'(CPU_BURST_MAX);
  localparam logic            C_SRC_IQ   = 1'b0;
  localparam logic            C_SRC_CPU  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_src;
  logic               r_last_src;
  logic [15:0]        r_n;
  logic [15:0]        r_cnt;
  logic [TMR_W-1:0]   r_flush_tmr;
  logic               r_underrun;

  logic [LVL_WIDTH-1:0]     w_iq_lvl_raw;
  logic [LVL_WIDTH-1:0]     w_cpu_lvl_raw;
  logic [15:0]              w_iq_lvl;
  logic [15:0]              w_cpu_lvl;
  logic                     w_cpu_elig;
  logic                     w_iq_norm;
  logic                     w_iq_flush;
  logic                     w_iq_elig;
  logic                     w_grant;
  logic                     w_grant_src;
  logic [15:0]              w_grant_n;
  logic                     w_src_empty;
  logic [FT_DATA_WIDTH-1:0] w_iq_word;
  logic [FT_DATA_WIDTH-1:0] w_hdr_word;
  logic [FT_DATA_WIDTH-1:0] w_data;
  logic                     w_rdy;
  logic                     w_pop;

  assign w_iq_lvl_raw  = bus.iq_level_i;
  assign w_cpu_lvl_raw = bus.cpu_level_i;
  assign w_iq_lvl      = 16'(w_iq_lvl_raw);
  assign w_cpu_lvl     = 16'(w_cpu_lvl_raw);

  // Levels are a read-side lower bound, so N taken from them never overruns the FIFO.
  assign w_cpu_elig  = !bus.cpu_empty_i && (w_cpu_lvl != 16'd0);
  assign w_iq_norm   = (w_iq_lvl >= C_IQ_BURST);
  assign w_iq_flush  = (r_flush_tmr == C_TMR_MAX) && (w_iq_lvl != 16'd0) && !bus.iq_empty_i;
  assign w_iq_elig   = w_iq_norm || w_iq_flush;
  assign w_grant     = (r_state == ST_IDLE) && (w_cpu_elig || w_iq_elig);
  assign w_grant_src = (w_cpu_elig && w_iq_elig) ? ~r_last_src
                                                 : (w_cpu_elig ? C_SRC_CPU : C_SRC_IQ);

  always_comb begin
    w_grant_n = 16'd0;
    if (w_grant_src == C_SRC_CPU) begin
      w_grant_n = (w_cpu_lvl > C_CPU_MAX) ? C_CPU_MAX : w_cpu_lvl;
    end else begin
      w_grant_n = w_iq_norm ? C_IQ_BURST : w_iq_lvl;
    end
  end

  assign w_src_empty = (r_src == C_SRC_CPU) ? bus.cpu_empty_i : bus.iq_empty_i;
  assign w_iq_word   = {4'h0, bus.iq_data_i[IQ_PAIR_WIDTH-1:IQ_HALF],
                        4'h0, bus.iq_data_i[IQ_HALF-1:0]};
  assign w_hdr_word  = {4'hA, r_src, 11'b0, r_n};

  // Outputs are forced quiet during reset so an abandoned burst cannot pop another word.
  always_comb begin
    w_rdy  = 1'b0;
    w_data = '0;
    if (!reset) begin
      unique case (r_state)
        ST_HDR: begin
          w_rdy  = 1'b1;
          w_data = w_hdr_word;
        end
        ST_PAYLOAD: begin
          w_rdy  = !w_src_empty;
          if (!w_src_empty) begin
            w_data = (r_src == C_SRC_CPU) ? bus.cpu_data_i : w_iq_word;
          end
        end
        default: begin
          w_rdy  = 1'b0;
          w_data = '0;
        end
      endcase
    end
  end

  assign w_pop = (r_state == ST_PAYLOAD) && w_rdy && bus.ft_re_i;

  assign bus.ft_rdy_o   = w_rdy;
  assign bus.ft_data_o  = w_data;
  assign bus.ft_last_o  = (r_state == ST_PAYLOAD) && (r_cnt == 16'd1) && w_rdy;
  assign bus.iq_re_o    = w_pop && (r_src == C_SRC_IQ);
  assign bus.cpu_re_o   = w_pop && (r_src == C_SRC_CPU);
  assign bus.underrun_o = r_underrun;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_src       <= C_SRC_IQ;
      r_last_src  <= C_SRC_IQ;
      r_n         <= 16'd0;
      r_cnt       <= 16'd0;
      r_flush_tmr <= '0;
      r_underrun  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state    <= ST_HDR;
            r_src      <= w_grant_src;
            r_last_src <= w_grant_src;
            r_n        <= w_grant_n;
          end
        end
        ST_HDR: begin
          if (bus.ft_re_i) begin
            r_state <= ST_PAYLOAD;
            r_cnt   <= r_n;
          end
        end
        ST_PAYLOAD: begin
          if (w_src_empty) begin
            r_underrun <= 1'b1;
          end
          if (w_pop) begin
            r_cnt <= r_cnt - 16'd1;
            if (r_cnt == 16'd1) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Flush timer only ages while IQ data sits below a full burst with nothing draining it.
      if (bus.iq_empty_i || (w_grant && (w_grant_src == C_SRC_IQ))) begin
        r_flush_tmr <= '0;
      end else if ((r_state == ST_IDLE) && !w_iq_norm && (r_flush_tmr != C_TMR_MAX)) begin
        r_flush_tmr <= r_flush_tmr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ft_wr_sched.sv
`default_nettype none
// Bench for ft_wr_sched: FIFO models, burst-level reference model, vector table,
// corner-case sequences and randomized traffic.
module tb_ft_wr_sched;
  localparam int IQ_BURST = 256;
  localparam int CPU_MAX  = 16;
  localparam int FLUSH    = 4096;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ft_wr_sched_if #(.FT_DATA_WIDTH(32), .IQ_PAIR_WIDTH(24), .LVL_WIDTH(10)) bus ();

  ft_wr_sched #(
    .FT_DATA_WIDTH(32), .IQ_PAIR_WIDTH(24), .LVL_WIDTH(10),
    .IQ_BURST(IQ_BURST), .CPU_BURST_MAX(CPU_MAX), .IQ_FLUSH_CYCLES(FLUSH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [23:0] iq_q[$];
  logic [31:0] cpu_q[$];
  bit          force_iq_empty;
  bit          chk_en;
  int          total;
  int          bad;

  // Reference model: one burst at a time, tracked as header-pending + words left.
  bit m_busy, m_hdr, m_src, m_last_src, m_under;
  int m_n, m_left, m_wait;

  logic [31:0] hdr_log[$];
  logic [31:0] first_pay;
  bit          got_first;
  int          dut_iq_pops, dut_cpu_pops;
  bit          last_rdy, last_under;

  typedef struct {
    int          n_cpu;
    int          n_iq;
    logic [31:0] exp_hdr;
    logic [31:0] exp_first;
    int          exp_cpu_pops;
    int          exp_iq_pops;
  } vec_t;
  vec_t vecs[8];

  function automatic bit iq_empty_now();
    return (iq_q.size() == 0) || force_iq_empty;
  endfunction

  function automatic logic [31:0] iq_word(input logic [23:0] p);
    return {4'h0, p[23:12], 4'h0, p[11:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
  endtask

  task automatic drive_inputs(input bit re);
    bus.ft_re_i     = re;
    bus.iq_empty_i  = iq_empty_now();
    bus.iq_level_i  = 10'(iq_q.size());
    bus.iq_data_i   = (iq_q.size() != 0) ? iq_q[0] : 24'h0;
    bus.cpu_empty_i = (cpu_q.size() == 0);
    bus.cpu_level_i = 10'(cpu_q.size());
    bus.cpu_data_i  = (cpu_q.size() != 0) ? cpu_q[0] : 32'h0;
  endtask

  task automatic step(input bit re);
    bit          s_empty, e_rdy, e_last, e_iqre, e_cpure;
    bit          iq_e, cpu_ok, iq_norm, iq_ok, iq_grant;
    logic [31:0] e_data;
    int          iql, cql;
    drive_inputs(re);
    @(negedge clk);
    s_empty = m_src ? (cpu_q.size() == 0) : iq_empty_now();
    e_rdy = 0; e_data = 32'h0; e_last = 0; e_iqre = 0; e_cpure = 0;
    if (!reset && m_busy) begin
      if (m_hdr) begin
        e_rdy  = 1;
        e_data = {4'hA, m_src, 11'b0, 16'(m_n)};
      end else if (!s_empty) begin
        e_rdy   = 1;
        e_data  = m_src ? cpu_q[0] : iq_word(iq_q[0]);
        e_last  = (m_left == 1);
        e_iqre  = re && !m_src;
        e_cpure = re && m_src;
      end
    end
    if (chk_en) begin
      check("ft_rdy", bus.ft_rdy_o, e_rdy);
      check("ft_data", bus.ft_data_o, e_data);
      check("ft_last", bus.ft_last_o, e_last);
      check("iq_re", bus.iq_re_o, e_iqre);
      check("cpu_re", bus.cpu_re_o, e_cpure);
      check("underrun", bus.underrun_o, m_under);
    end
    if (!reset && m_busy && m_hdr && re) hdr_log.push_back(bus.ft_data_o);
    if (!reset && m_busy && !m_hdr && !s_empty && (m_left == m_n) && !got_first) begin
      first_pay = bus.ft_data_o;
      got_first = 1;
    end
    last_rdy   = bus.ft_rdy_o;
    last_under = bus.underrun_o;
    if (bus.iq_re_o) dut_iq_pops++;
    if (bus.cpu_re_o) dut_cpu_pops++;
    @(posedge clk);
    #1;
    if (reset) begin
      m_busy = 0; m_hdr = 0; m_under = 0; m_last_src = 0; m_wait = 0; m_src = 0;
    end else begin
      iq_e     = iq_empty_now();
      iql      = iq_q.size();
      cql      = cpu_q.size();
      iq_grant = 0;
      if (m_busy && !m_hdr) begin
        if (s_empty) m_under = 1;
        else if (re) begin
          if (m_src) void'(cpu_q.pop_front());
          else void'(iq_q.pop_front());
          m_left--;
          if (m_left == 0) m_busy = 0;
        end
      end else if (m_busy) begin
        if (re) begin
          m_hdr  = 0;
          m_left = m_n;
        end
      end else begin
        cpu_ok  = (cql != 0);
        iq_norm = (iql >= IQ_BURST);
        iq_ok   = iq_norm || ((m_wait == FLUSH - 1) && (iql != 0) && !iq_e);
        if (cpu_ok || iq_ok) begin
          m_src      = (cpu_ok && iq_ok) ? !m_last_src : cpu_ok;
          m_n        = m_src ? ((cql > CPU_MAX) ? CPU_MAX : cql) : (iq_norm ? IQ_BURST : iql);
          m_last_src = m_src;
          m_busy     = 1;
          m_hdr      = 1;
          iq_grant   = !m_src;
        end
        if (!iq_e && !iq_grant && !iq_norm && (m_wait < FLUSH - 1)) m_wait++;
      end
      if (iq_e || iq_grant) m_wait = 0;
    end
  endtask

  task automatic prepare();
    iq_q.delete();
    cpu_q.delete();
    force_iq_empty = 0;
    reset = 1;
    step(0);
    reset = 0;
    hdr_log.delete();
    got_first    = 0;
    dut_iq_pops  = 0;
    dut_cpu_pops = 0;
  endtask

  initial begin
    bit started;
    int flush_k;
    int pops_before;
    total = 0; bad = 0; chk_en = 0; force_iq_empty = 0;
    m_busy = 0; m_hdr = 0; m_src = 0; m_last_src = 0; m_under = 0;
    m_n = 0; m_left = 0; m_wait = 0;
    reset = 1;
    step(0);
    step(0);
    reset = 0;
    chk_en = 1;

    vecs[0] = '{3,   0,   32'hA8000003, 32'hDEADBEEF, 3,  0};
    vecs[1] = '{20,  0,   32'hA8000010, 32'hDEADBEEF, 16, 0};
    vecs[2] = '{16,  0,   32'hA8000010, 32'hDEADBEEF, 16, 0};
    vecs[3] = '{1,   0,   32'hA8000001, 32'hDEADBEEF, 1,  0};
    vecs[4] = '{0,   300, 32'hA0000100, 32'h0ABC0123, 0,  256};
    vecs[5] = '{0,   256, 32'hA0000100, 32'h0ABC0123, 0,  256};
    vecs[6] = '{7,   400, 32'hA8000007, 32'hDEADBEEF, 7,  0};
    vecs[7] = '{17,  0,   32'hA8000010, 32'hDEADBEEF, 16, 0};

    for (int v = 0; v < 8; v++) begin
      prepare();
      for (int i = 0; i < vecs[v].n_cpu; i++)
        cpu_q.push_back((i == 0) ? 32'hDEADBEEF : 32'($urandom));
      for (int i = 0; i < vecs[v].n_iq; i++)
        iq_q.push_back((i == 0) ? 24'hABC123 : 24'($urandom));
      started = 0;
      for (int c = 0; c < 800; c++) begin
        step(1);
        if (m_busy) started = 1;
        if (started && !m_busy) break;
      end
      if (!started || m_busy) note_timeout("vec_burst");
      check("vec_hdr", (hdr_log.size() != 0) ? hdr_log[0] : 32'h0, vecs[v].exp_hdr);
      check("vec_first", first_pay, vecs[v].exp_first);
      check("vec_cpu_pops", dut_cpu_pops, vecs[v].exp_cpu_pops);
      check("vec_iq_pops", dut_iq_pops, vecs[v].exp_iq_pops);
    end

    // Both sources eligible throughout: grants must alternate starting with CPU.
    prepare();
    for (int i = 0; i < 40; i++) cpu_q.push_back(32'($urandom));
    for (int i = 0; i < 600; i++) iq_q.push_back(24'($urandom));
    for (int c = 0; c < 2000; c++) begin
      if (hdr_log.size() >= 4) break;
      step(1);
    end
    if (hdr_log.size() < 4) note_timeout("alternate");
    else begin
      check("alt0", hdr_log[0], 32'hA8000010);
      check("alt1", hdr_log[1], 32'hA0000100);
      check("alt2", hdr_log[2], 32'hA8000010);
      check("alt3", hdr_log[3], 32'hA0000100);
    end

    // Short IQ backlog: header only after the flush timer has aged to its limit.
    prepare();
    for (int i = 0; i < 5; i++) iq_q.push_back(24'($urandom));
    flush_k = -1;
    for (int k = 0; k < 4400; k++) begin
      step(1);
      if (last_rdy && flush_k < 0) flush_k = k;
      if (flush_k >= 0 && k > flush_k + 20) break;
    end
    check("flush_delay", flush_k, 4096);
    check("flush_hdr", (hdr_log.size() != 0) ? hdr_log[0] : 32'h0, 32'hA0000005);
    check("flush_pops", dut_iq_pops, 5);

    // Throttled consumer plus a forced empty gap mid-payload.
    prepare();
    for (int i = 0; i < 300; i++) iq_q.push_back(24'($urandom));
    for (int c = 0; c < 20; c++) begin
      step(1);
      if (m_busy && !m_hdr) break;
    end
    for (int i = 0; i < 40; i++) begin
      force_iq_empty = (i >= 10 && i < 13);
      step(i % 2 == 0);
    end
    force_iq_empty = 0;
    for (int c = 0; c < 600; c++) begin
      if (!m_busy) break;
      step(1);
    end
    if (m_busy) note_timeout("stall_burst");
    check("stall_pops", dut_iq_pops, 256);
    check("stall_underrun", bus.underrun_o, 1'b1);

    // Reset in the middle of an IQ payload.
    prepare();
    for (int i = 0; i < 300; i++) iq_q.push_back(24'($urandom));
    for (int c = 0; c < 100; c++) begin
      step(1);
      if (dut_iq_pops >= 10) break;
    end
    check("rst_pre_pops", dut_iq_pops, 10);
    for (int i = 0; i < 5; i++) cpu_q.push_back(32'($urandom));
    pops_before = dut_iq_pops;
    reset = 1;
    step(1);
    reset = 0;
    hdr_log.delete();
    step(1);
    check("rst_rdy", last_rdy, 1'b0);
    check("rst_under", last_under, 1'b0);
    check("rst_no_pop", dut_iq_pops, pops_before);
    for (int c = 0; c < 20; c++) begin
      if (hdr_log.size() != 0) break;
      step(1);
    end
    check("rst_next_hdr", (hdr_log.size() != 0) ? hdr_log[0] : 32'h0, 32'hA8000005);

    // Randomized traffic against the reference model.
    prepare();
    for (int c = 0; c < 5000; c++) begin
      if ($urandom_range(0, 99) < 30 && iq_q.size() < 900) iq_q.push_back(24'($urandom));
      if ($urandom_range(0, 99) < 8 && cpu_q.size() < 900) cpu_q.push_back(32'($urandom));
      step($urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
